// File: rtl/seq_nr_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_nr_divider
//  Description : Multi-cycle signed non-restoring divider, one quotient bit
//                per clock, with divide-by-zero and MIN/-1 overflow flags.
//                Optional macro SEQ_DIV_EARLY_EXIT_EN skips iteration when
//                either operand is zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_nr_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_early;
    logic             w_early_cond;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_p;
    logic [WIDTH:0]   r_dmag;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_dividend;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_dbz;
    logic             r_ovf;

    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;
    logic             r_overflow;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH:0]   w_dvs_mag;
    logic [WIDTH:0]   w_p_sh;
    logic [WIDTH:0]   w_p_nxt;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_r_mag;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

`ifdef SEQ_DIV_EARLY_EXIT_EN
    assign w_early_cond = (divisor == '0) || (dividend == '0);
`else
    assign w_early_cond = 1'b0;
`endif

    // |MIN| = 2^(WIDTH-1) is exact as an unsigned WIDTH-bit value; the divisor
    // magnitude is kept WIDTH+1 bits wide to match the signed partial remainder.
    assign w_dvd_mag = dividend[WIDTH-1] ? ({WIDTH{1'b0}} - dividend) : dividend;
    assign w_dvs_mag = divisor[WIDTH-1]
                     ? ({(WIDTH+1){1'b0}} - {divisor[WIDTH-1], divisor})
                     : {1'b0, divisor};

    assign w_p_sh  = {r_p[WIDTH-1:0], r_a[WIDTH-1]};
    assign w_p_nxt = r_p[WIDTH] ? (w_p_sh + r_dmag) : (w_p_sh - r_dmag);
    assign w_a_nxt = {r_a[WIDTH-2:0], ~w_p_nxt[WIDTH]};

    // Final correction: a negative partial remainder is restored once.
    assign w_r_mag = r_p[WIDTH] ? (r_p[WIDTH-1:0] + r_dmag[WIDTH-1:0]) : r_p[WIDTH-1:0];
    assign w_quot  = r_dbz ? {WIDTH{1'b1}}
                   : (r_q_neg ? ({WIDTH{1'b0}} - r_a) : r_a);
    assign w_rem   = r_dbz ? r_dividend
                   : (r_r_neg ? ({WIDTH{1'b0}} - w_r_mag) : w_r_mag);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_early     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_early     = w_early_cond;
                    w_state_nxt = w_early_cond ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_p           <= '0;
            r_dmag        <= '0;
            r_a           <= '0;
            r_dividend    <= '0;
            r_q_neg       <= 1'b0;
            r_r_neg       <= 1'b0;
            r_dbz         <= 1'b0;
            r_ovf         <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt      <= '0;
                r_p        <= '0;
                r_a        <= w_dvd_mag;
                r_dmag     <= w_dvs_mag;
                r_dividend <= dividend;
                r_q_neg    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                r_r_neg    <= dividend[WIDTH-1];
                r_dbz      <= (divisor == '0);
                r_ovf      <= (dividend == C_MIN) && (divisor == {WIDTH{1'b1}});
                if (w_early) begin
                    // Either operand is zero: the remainder is the dividend either way.
                    r_quotient    <= (divisor == '0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
                    r_remainder   <= dividend;
                    r_div_by_zero <= (divisor == '0);
                    r_overflow    <= 1'b0;
                end else begin
                    r_div_by_zero <= 1'b0;
                    r_overflow    <= 1'b0;
                end
            end
            if (r_state == S_CALC) begin
                r_p   <= w_p_nxt;
                r_a   <= w_a_nxt;
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == S_FIX) begin
                r_quotient    <= w_quot;
                r_remainder   <= w_rem;
                r_div_by_zero <= r_dbz;
                r_overflow    <= r_ovf;
            end
        end
    end

    assign busy        = (r_state == S_CALC) || (r_state == S_FIX);
    assign done        = (r_state == S_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_seq_nr_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_nr_divider
//  Description : Self-checking bench for seq_nr_divider at WIDTH=8 and 16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_nr_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [7:0]  dvd8, dvs8, q8, r8;
    logic [15:0] dvd16, dvs16, q16, r16;
    logic        busy8, done8, dbz8, ovf8;
    logic        busy16, done16, dbz16, ovf16;

    always #5 clk = ~clk;

    seq_nr_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .dividend(dvd8), .divisor(dvs8),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8),
        .div_by_zero(dbz8), .overflow(ovf8)
    );

    seq_nr_divider #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .dividend(dvd16), .divisor(dvs16),
        .busy(busy16), .done(done16), .quotient(q16), .remainder(r16),
        .div_by_zero(dbz16), .overflow(ovf16)
    );

    typedef struct {
        string       tag;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: SV integer division truncates toward zero, % follows the dividend.
    function automatic exp_t model(input string tag, input int w, input int a, input int b);
        exp_t e;
        int   qi, ri;
        int   mask = (1 << w) - 1;
        int   minv = -(1 << (w - 1));
        e.tag = tag;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (b == 0) begin
            qi = -1; ri = a; e.dbz = 1'b1;
        end else if (a == minv && b == -1) begin
            qi = minv; ri = 0; e.ovf = 1'b1;
        end else begin
            qi = a / b; ri = a % b;
        end
        e.q = 16'(qi & mask);
        e.r = 16'(ri & mask);
`ifdef SEQ_DIV_EARLY_EXIT_EN
        e.lat = (a == 0 || b == 0) ? 1 : w + 2;
`else
        e.lat = w + 2;
`endif
        return e;
    endfunction

    task automatic run(input string tag, input bit wide, input int a, input int b);
        exp_t e;
        int   n;
        bit   seen;
        @(negedge clk);
        if (wide) begin
            dvd16 = 16'(a); dvs16 = 16'(b); start16 = 1'b1;
        end else begin
            dvd8 = 8'(a); dvs8 = 8'(b); start8 = 1'b1;
        end
        sb.push_back(model(tag, wide ? 16 : 8, a, b));
        @(posedge clk); #1;
        start8 = 1'b0; start16 = 1'b0;
        dvd8 = ~dvd8; dvs8 = ~dvs8; dvd16 = ~dvd16; dvs16 = ~dvs16;
        check({tag, " busy"}, wide ? busy16 : busy8, (sb[0].lat > 1));
        n = 1;
        seen = 1'b0;
        while (!seen && n <= 40) begin
            if (wide ? done16 : done8) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        e = sb.pop_front();
        check({tag, " done seen"}, seen, 1'b1);
        if (seen) begin
            check({tag, " latency"}, n, e.lat);
            check({tag, " quotient"}, wide ? q16 : {8'h00, q8}, e.q);
            check({tag, " remainder"}, wide ? r16 : {8'h00, r8}, e.r);
            check({tag, " div_by_zero"}, wide ? dbz16 : dbz8, e.dbz);
            check({tag, " overflow"}, wide ? ovf16 : ovf8, e.ovf);
            @(posedge clk); #1;
            check({tag, " done pulse"}, wide ? done16 : done8, 1'b0);
            check({tag, " quotient hold"}, wide ? q16 : {8'h00, q8}, e.q);
        end
    endtask

    initial begin
        exp_t        e;
        int          n_done;
        logic [7:0]  q_cap;
        rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
        dvd8 = '0; dvs8 = '0; dvd16 = '0; dvs16 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy8, 1'b0);
        check("reset done", done8, 1'b0);
        check("reset quotient", q8, 8'h00);
        check("reset remainder", r8, 8'h00);
        check("reset dbz", dbz8, 1'b0);
        check("reset ovf", ovf8, 1'b0);
        rst = 1'b0;

        run("100/5",   1'b0,  100,  5);
        run("-100/5",  1'b0, -100,  5);
        run("100/-5",  1'b0,  100, -5);
        run("-100/-5", 1'b0, -100, -5);
        run("45/7",    1'b0,   45,  7);
        run("-45/7",   1'b0,  -45,  7);
        run("45/-7",   1'b0,   45, -7);
        run("127/3",   1'b0,  127,  3);
        run("50/0",    1'b0,   50,  0);
        run("-128/-1", 1'b0, -128, -1);
        run("-128/2",  1'b0, -128,  2);
        run("0/5",     1'b0,    0,  5);
        run("-7/-128", 1'b0,   -7, -128);
        run("w16 -32768/7",  1'b1, -32768, 7);
        run("w16 32767/-1",  1'b1,  32767, -1);
        run("w16 -32768/-1", 1'b1, -32768, -1);

        // start held and operands scrambled while the division is in flight
        @(negedge clk);
        dvd8 = 8'd100; dvs8 = 8'd5; start8 = 1'b1;
        sb.push_back(model("pulse", 8, 100, 5));
        n_done = 0;
        q_cap  = '0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (done8) begin
                n_done++;
                q_cap = q8;
            end
            if (i == 7) start8 = 1'b0;
            else if (i < 7) begin
                dvd8 = 8'($urandom);
                dvs8 = 8'($urandom);
            end
        end
        e = sb.pop_front();
        check("pulse done count", n_done, 1);
        check("pulse quotient", q_cap, e.q[7:0]);

        // reset mid-division
        @(negedge clk);
        dvd8 = 8'(-45); dvs8 = 8'd7; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst busy", busy8, 1'b0);
        check("midrst done", done8, 1'b0);
        check("midrst quotient", q8, 8'h00);
        check("midrst remainder", r8, 8'h00);
        check("midrst dbz", dbz8, 1'b0);
        check("midrst ovf", ovf8, 1'b0);
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done8) n_done++;
        end
        check("midrst no done", n_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
